// File: rtl/mips_bus_pkg.sv
// Shared types for the data-memory bridge: FSM state encoding, bus request
// bundle, and the fill word returned when a read response never arrives.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } dmem_state_e;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  // Only whole-word accesses are legal on this bus.
  function automatic logic is_misaligned(input logic [31:0] byte_addr);
    return byte_addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Read-response watchdog. Counts cycles while enabled; expired is high in the
// RSP_TIMEOUT-th consecutive enabled cycle and the count then holds.
module dmem_timeout_ctr #(
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RSP_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, saturate once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Core data-port to request/response bus bridge. Word accesses only; a read
// that gets no response within RSP_TIMEOUT cycles completes with a fault and
// the fill word. Optional feature macro: DMEM_STORE_BUFFER_EN adds a single
// posted-write entry so aligned stores do not stall the core.
module dmem_bridge
  import mips_bus_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] aluresult,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  dmem_state_e state_q;
  bus_req_t    req_q;
  logic [31:0] data_q;
  logic        tout_q;
`ifdef DMEM_STORE_BUFFER_EN
  logic        posted_q;
`endif

  logic access;
  logic misaligned;
  logic aligned_access;
  logic expired;

  // Reset masks the access decode so every output reads as idle during reset.
  assign access         = (memread || memwrite) && !reset;
  assign misaligned     = access && is_misaligned(aluresult);
  assign aligned_access = access && !misaligned;

  dmem_timeout_ctr #(
    .RSP_TIMEOUT(RSP_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == WAIT_RSP),
    .clear  (state_q != WAIT_RSP),
    .expired(expired)
  );

  // Transaction FSM: latches the request, tracks the bus handshake and the
  // response or timeout, and holds the completed data for one DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      data_q   <= '0;
      tout_q   <= 1'b0;
`ifdef DMEM_STORE_BUFFER_EN
      posted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (aligned_access) begin
            req_q.valid <= 1'b1;
            req_q.write <= memwrite;
            req_q.addr  <= word_align(aluresult);
            req_q.wdata <= writedata;
            data_q      <= '0;
            tout_q      <= 1'b0;
`ifdef DMEM_STORE_BUFFER_EN
            posted_q    <= memwrite;
`endif
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            req_q.valid <= 1'b0;
`ifdef DMEM_STORE_BUFFER_EN
            // A posted store has already released the core: drain silently.
            if (posted_q) begin
              posted_q <= 1'b0;
              state_q  <= IDLE;
            end else
`endif
            if (req_q.write) begin
              state_q <= DONE;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // A response arriving in the expiry cycle still wins.
          if (bus_rsp_valid) begin
            data_q  <= bus_rsp_rdata;
            state_q <= DONE;
          end else if (expired) begin
            data_q  <= TIMEOUT_DATA;
            tout_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          tout_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Core hold: raised the same cycle an aligned access is seen and kept until
  // the transaction reaches DONE.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef DMEM_STORE_BUFFER_EN
        stall = aligned_access && !memwrite;
`else
        stall = aligned_access;
`endif
      end
      REQ: begin
`ifdef DMEM_STORE_BUFFER_EN
        // While the posted store drains, only a new access has to wait.
        stall = posted_q ? access : 1'b1;
`else
        stall = 1'b1;
`endif
      end
      WAIT_RSP: stall = 1'b1;
      DONE:     stall = 1'b0;
      default:  stall = 1'b0;
    endcase
  end

  // Fault is immediate for a misaligned access, and accompanies the fill word
  // in DONE after a timeout.
  always_comb begin
    fault    = 1'b0;
    readdata = '0;
    if (state_q == IDLE) begin
      fault = misaligned;
    end
    if (state_q == DONE) begin
      fault    = tout_q;
      readdata = data_q;
    end
  end

  assign bus_req_valid = req_q.valid;
  assign bus_req_write = req_q.write;
  assign bus_req_addr  = req_q.addr;
  assign bus_req_wdata = req_q.wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_dmem_bridge;

  localparam int TMO = 64;
`ifdef DMEM_STORE_BUFFER_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] aluresult;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        fault;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  dmem_bridge #(.RSP_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .memread      (memread),
    .memwrite     (memwrite),
    .aluresult    (aluresult),
    .writedata    (writedata),
    .readdata     (readdata),
    .stall        (stall),
    .fault        (fault),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write),
    .bus_req_addr (bus_req_addr),
    .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: an outstanding request, an outstanding read,
  // and a completion that is reported for one cycle.
  bit          m_req, m_posted, m_wait, m_done, m_tout, m_write;
  logic [31:0] m_addr, m_wdata, m_data;
  int          m_age;
  bit          prev_rst = 1'b0;
  bit          e_stall_last = 1'b0;
  bit          hsq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One clock of checking: compare the DUT against the model at the falling
  // edge, then advance the model across the coming rising edge.
  task automatic tick();
    bit ev, es, ef, crd;
    logic [31:0] er;
    @(negedge clk);
    ev = 0; es = 0; ef = 0; crd = 1; er = '0;
    if (reset) begin
      if (prev_rst) begin
        chk("rst_valid", bus_req_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fault", fault, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_addr", bus_req_addr, 0);
        chk("rst_wdata", bus_req_wdata, 0);
        chk("rst_write", bus_req_write, 0);
      end
      m_req = 0; m_posted = 0; m_wait = 0; m_done = 0; m_tout = 0; m_age = 0;
    end else begin
      if (m_done) begin
        er = m_data; ef = m_tout; crd = !m_write;
        m_done = 0;
      end else if (m_req) begin
        ev = 1;
        es = m_posted ? (memread | memwrite) : 1'b1;
        if (bus_req_ready) begin
          m_req = 0;
          if (m_posted) m_posted = 0;
          else if (m_write) begin m_done = 1; m_tout = 0; end
          else begin m_wait = 1; m_age = 0; end
        end
      end else if (m_wait) begin
        es = 1;
        m_age++;
        if (bus_rsp_valid) begin
          m_data = bus_rsp_rdata; m_tout = 0; m_done = 1; m_wait = 0;
        end else if (m_age == TMO) begin
          m_data = 32'hDEADBEEF; m_tout = 1; m_done = 1; m_wait = 0;
        end
      end else if (memread | memwrite) begin
        if (aluresult[1:0] != 2'b00) begin
          ef = 1;
        end else begin
          m_req = 1; m_write = memwrite; m_addr = aluresult; m_wdata = writedata;
          m_posted = SB && memwrite;
          es = !m_posted;
        end
      end
      chk("stall", stall, es);
      chk("fault", fault, ef);
      chk("bus_req_valid", bus_req_valid, ev);
      if (crd) chk("readdata", readdata, er);
      if (ev) begin
        chk("bus_req_addr", bus_req_addr, m_addr);
        chk("bus_req_wdata", bus_req_wdata, m_wdata);
        chk("bus_req_write", bus_req_write, m_write);
      end
    end
    if (!reset && bus_req_valid && bus_req_ready) hsq.push_back(bus_req_write);
    prev_rst = reset;
    e_stall_last = es;
  endtask

  // Aligned load with ready held high and the response one cycle after the
  // handshake. Entered and left just after a rising edge.
  task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                         output int stalls, output bit done);
    bit hs;
    stalls = 0; done = 0; hs = 0;
    memread = 1; memwrite = 0; aluresult = addr; bus_req_ready = 1;
    bus_rsp_valid = 0; bus_rsp_rdata = data;
    for (int i = 0; i < 12 && !done; i++) begin
      tick();
      if (stall) stalls++;
      else begin
        done = 1;
        chk("load_rdata", readdata, data);
      end
      hs = bus_req_valid && bus_req_ready;
      next();
      bus_rsp_valid = hs;
      if (done) begin memread = 0; bus_rsp_valid = 0; bus_req_ready = 0; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sc, hs;
    bit  dn, adv, hsr, dead;
    logic [31:0] a;

    reset = 1; memread = 0; memwrite = 0; aluresult = '0; writedata = '0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = '0;
    tick();
    next();
    tick();
    chk("reset_stall_lit", stall, 0);
    chk("reset_readdata_lit", readdata, 0);
    next();
    reset = 0;

    // Minimum-latency load.
    do_load(32'h100, 32'h12345678, sc, dn);
    chk("load_stall_cycles", sc, 3);
    chk("load_done_seen", dn, 1);

    // Store held off by ready for 5 cycles.
    memwrite = 1; aluresult = 32'h204; writedata = 32'hCAFEF00D; bus_req_ready = 0;
    tick();
    adv = !stall;
    hs = 0;
    for (int r = 0; r < 6; r++) begin
      next();
      if (adv) memwrite = 0;
      bus_req_ready = (r == 5);
      tick();
      chk("st_valid", bus_req_valid, 1);
      chk("st_addr", bus_req_addr, 32'h204);
      chk("st_wdata", bus_req_wdata, 32'hCAFEF00D);
      chk("st_write", bus_req_write, 1);
      chk("st_fault", fault, 0);
      if (bus_req_valid && bus_req_ready) hs++;
      if (!stall) adv = 1;
    end
    next();
    bus_req_ready = 0;
    if (adv) memwrite = 0;
    tick();
    chk("st_after_stall", stall, 0);
    chk("st_after_fault", fault, 0);
    chk("st_after_valid", bus_req_valid, 0);
    next();
    memwrite = 0;
    chk("st_handshakes", hs, 1);

    // Misaligned load.
    memread = 1; aluresult = 32'h102;
    tick();
    chk("mis_fault", fault, 1);
    chk("mis_valid", bus_req_valid, 0);
    chk("mis_stall", stall, 0);
    chk("mis_readdata", readdata, 0);
    next();
    memread = 0;
    tick();
    chk("mis_fault_pulse", fault, 0);
    next();

    // Read timeout, then a late response that must be discarded.
    memread = 1; aluresult = 32'h40; bus_req_ready = 1; bus_rsp_valid = 0;
    sc = 0; dn = 0;
    for (int i = 0; i < TMO + 10 && !dn; i++) begin
      bit h;
      tick();
      if (stall) sc++;
      else begin
        dn = 1;
        chk("tmo_readdata", readdata, 32'hDEADBEEF);
        chk("tmo_fault", fault, 1);
      end
      h = bus_req_valid && bus_req_ready;
      next();
      if (h) bus_req_ready = 0;
      if (dn) memread = 0;
    end
    chk("tmo_stall_cycles", sc, TMO + 2);
    tick();
    chk("tmo_fault_pulse", fault, 0);
    next();
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h11111111;
    tick();
    chk("late_rsp_stall", stall, 0);
    chk("late_rsp_readdata", readdata, 0);
    chk("late_rsp_valid", bus_req_valid, 0);
    next();
    bus_rsp_valid = 0;

    // Reset while waiting for a response.
    memread = 1; aluresult = 32'h80; bus_req_ready = 1;
    tick();
    next();
    tick();
    next();
    bus_req_ready = 0;
    tick();
    next();
    reset = 1;
    tick();
    next();
    reset = 0; memread = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'h77777777;
    tick();
    chk("rst_mid_valid", bus_req_valid, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_readdata", readdata, 0);
    next();
    bus_rsp_valid = 0;
    do_load(32'h84, 32'h55AA33CC, sc, dn);
    chk("post_rst_load_stalls", sc, 3);
    chk("post_rst_load_done", dn, 1);

`ifdef DMEM_STORE_BUFFER_EN
    // Posted store followed immediately by a load.
    hsq.delete();
    memwrite = 1; aluresult = 32'h300; writedata = 32'hA5A5A5A5; bus_req_ready = 0;
    tick();
    chk("sb_store_nostall", stall, 0);
    next();
    memwrite = 0; memread = 1; aluresult = 32'h104;
    dn = 0; hsr = 0;
    for (int k = 0; k < 30 && !dn; k++) begin
      bus_req_ready = (k >= 3);
      bus_rsp_valid = hsr;
      bus_rsp_rdata = 32'h0BADF00D;
      tick();
      if (bus_req_valid && bus_req_write) chk("sb_load_waits", stall, 1);
      if (!stall) begin
        dn = 1;
        chk("sb_load_rdata", readdata, 32'h0BADF00D);
      end
      hsr = bus_req_valid && bus_req_ready && !bus_req_write;
      next();
    end
    memread = 0; bus_req_ready = 0; bus_rsp_valid = 0;
    chk("sb_load_done", dn, 1);
    chk("sb_hs_count", hsq.size(), 2);
    if (hsq.size() >= 2) begin
      chk("sb_order_first_store", hsq[0], 1);
      chk("sb_order_then_load", hsq[1], 0);
    end
`endif

    // Random traffic against the model.
    adv = 1; dead = 0;
    for (int c = 0; c < 4000; c++) begin
      int kind;
      reset = ($urandom_range(0, 299) == 0);
      if (adv) begin
        kind = $urandom_range(0, 9);
        a = $urandom();
        a[1:0] = 2'b00;
        memread = 0; memwrite = 0;
        writedata = $urandom();
        case (kind)
          3, 4, 5: memread = 1;
          6, 7:    memwrite = 1;
          8:       begin memread = 1; memwrite = 1; end
          9: begin
            a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) memread = 1; else memwrite = 1;
          end
          default: ;
        endcase
        aluresult = a;
      end
      bus_req_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) dead = !dead;
      bus_rsp_valid = !dead && ($urandom_range(0, 3) == 0);
      bus_rsp_rdata = $urandom();
      tick();
      adv = !e_stall_last;
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter RSP_TIMEOUT, default 64, SHALL set the number of cycles waited for a read response before a fault.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- memread  in  1  core data load request
- memwrite  in  1  core data store request
- aluresult  in  32  core byte address
- writedata  in  32  core store data
- readdata  out  32  load data to core
- stall  out  1  core hold; the core advances only on edges where stall=0
- fault  out  1  one-cycle pulse: misaligned access or read timeout
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus request accept
- bus_req_write  out  1  1=store, 0=load
- bus_req_addr  out  32  word-aligned bus address
- bus_req_wdata  out  32  store data
- bus_rsp_valid  in  1  read response valid
- bus_rsp_rdata  in  32  read response data

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT_RSP and DONE.
REQ-004 Only word accesses SHALL be supported; aluresult[1:0]!=0 with memread or memwrite in IDLE SHALL pulse fault for 1 cycle, issue no bus request, hold stall=0, and drive readdata=0.
REQ-005 IDLE with an aligned access SHALL drive stall=1 combinationally, latch the address, data and direction, and go to REQ; if memread and memwrite are both high, the write SHALL win.
REQ-006 REQ SHALL hold bus_req_valid=1 with addr, wdata and write stable until the cycle in which bus_req_ready=1; a write then goes to DONE and a read goes to WAIT_RSP.
REQ-007 WAIT_RSP SHALL capture bus_rsp_rdata on bus_rsp_valid=1 and go to DONE.
REQ-008 WAIT_RSP SHALL count cycles; on reaching RSP_TIMEOUT it SHALL pulse fault, load 32'hDEADBEEF as the read data, and go to DONE.
REQ-009 DONE SHALL drive stall=0 and readdata equal to the captured data for exactly 1 cycle, then return to IDLE.
REQ-010 bus_rsp_valid SHALL be ignored in IDLE, REQ and DONE, so a late response after a timeout is discarded.
REQ-011 Minimum read latency (ready in REQ, response on the next cycle) SHALL be 4 cycles, from the access presented to DONE: IDLE, REQ, WAIT_RSP, DONE.
REQ-012 stall SHALL be 1 in REQ and WAIT_RSP; bus_req_valid SHALL be 0 outside REQ.

Reset
REQ-013 On reset the FSM SHALL enter IDLE, the timeout counter SHALL clear, and the captured data SHALL clear to 0.
REQ-014 Reset values of the outputs SHALL be: bus_req_valid=0, fault=0, stall=0, readdata=0, and bus_req_addr, bus_req_wdata and bus_req_write all 0.
REQ-015 Reset asserted mid-transaction SHALL drop bus_req_valid at the next edge and abandon the transaction; any later response SHALL be ignored per REQ-010.

Configuration
REQ-016 Macro DMEM_STORE_BUFFER_EN defined: an aligned write in IDLE SHALL load a 1-entry posted-write buffer and hold stall=0 in that cycle, and the buffer SHALL drain via REQ with no DONE cycle.
REQ-017 With DMEM_STORE_BUFFER_EN defined, any access while the buffer is occupied SHALL stall until the drain handshake completes, preserving program order.
REQ-018 DMEM_STORE_BUFFER_EN undefined: writes SHALL stall through REQ and DONE as in REQ-005 to REQ-009, and no buffer storage SHALL be synthesised.

Structure
REQ-019 Package mips_bus_pkg SHALL hold the FSM state enum, the bus request struct (valid, write, addr, wdata), and the constant TIMEOUT_DATA=32'hDEADBEEF.
REQ-020 The timeout counter SHALL be a sub-module dmem_timeout_ctr (inputs: clk, reset, enable, clear; output: expired).

Verification
REQ-021 Aligned load to 0x100, ready held at 1, rsp_valid one cycle after the handshake with rdata 0x12345678: stall=1 for 3 cycles, then readdata=0x12345678 with stall=0 in DONE.
REQ-022 Store to 0x204 of 0xCAFEF00D with ready low for 5 cycles: bus_req_valid, addr and wdata stay stable for all 6 REQ cycles; one handshake occurs; no fault.
REQ-023 Load to 0x102: fault pulses 1 cycle, bus_req_valid stays 0, stall=0, readdata=0.
REQ-024 Load accepted but no response for 64 cycles: fault pulses, readdata=0xDEADBEEF in DONE; a rsp_valid 2 cycles later is ignored.
REQ-025 Reset asserted during WAIT_RSP: next cycle state=IDLE, bus_req_valid=0, stall=0; a following load completes normally.
REQ-026 With DMEM_STORE_BUFFER_EN, a store followed by a load on the next cycle, with ready delayed 3 cycles: the store reports stall=0, the load stalls until the store handshake completes, and bus order is store then load.
